// File: rtl/alu_request_arbiter_pkg.sv
// Shared definitions for the ALU request arbiter: ALU function codes, flag
// bit positions and the arbiter state encoding.
package alu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_FUN_W  = 5;

  // FunSel[3:0] operation codes; FunSel[4] selects 32-bit width
  localparam logic [3:0] FS_ADD = 4'b0100;
  localparam logic [3:0] FS_ADC = 4'b0101;
  localparam logic [3:0] FS_SUB = 4'b0110;
  localparam logic [3:0] FS_AND = 4'b0111;
  localparam logic [3:0] FS_OR  = 4'b1000;
  localparam logic [3:0] FS_XOR = 4'b1001;
  localparam logic [3:0] FS_LSL = 4'b1011;
  localparam int         FS_WIDTH32_BIT = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  function automatic logic [DEF_FUN_W-1:0] fun32(input logic [3:0] op);
    return {1'b1, op};
  endfunction

endpackage

// File: rtl/alu_request_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins, on a tie the port that
// was not granted last time wins.
module rr_arbiter2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_grant,
  output logic o_any
);

  assign o_any   = i_valid0 | i_valid1;
  assign o_grant = (i_valid0 & i_valid1) ? ~i_last_grant : i_valid1;

endmodule

// File: rtl/alu_request_arbiter.sv
// Shares one ALU between two valid/ready requesters; one operation in flight,
// result returned with the ALU's registered flags.
module alu_request_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FUN_W  = DEF_FUN_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_A,
  input  logic [DATA_W-1:0] req0_B,
  input  logic [FUN_W-1:0]  req0_FunSel,
  input  logic              req0_WF,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_A,
  input  logic [DATA_W-1:0] req1_B,
  input  logic [FUN_W-1:0]  req1_FunSel,
  input  logic              req1_WF,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        rsp_flags,
  output logic [DATA_W:0]   alu_A,
  output logic [DATA_W:0]   alu_B,
  output logic [FUN_W-1:0]  alu_FunSel,
  output logic              alu_WF,
  input  logic [DATA_W:0]   alu_ALUOut,
  input  logic [3:0]        alu_Flags
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic              r_last_grant;
  logic              r_owner;
  logic [DATA_W-1:0] r_op_A;
  logic [DATA_W-1:0] r_op_B;
  logic [FUN_W-1:0]  r_op_fun;
  logic              r_op_wf;
  logic [DATA_W-1:0] r_result;

  logic w_grant;
  logic w_any;
  logic w_accept;
  logic w_rsp_ready;
  logic w_unused_carry;

  rr_arbiter2 u_rr (
    .i_valid0     (req0_valid),
    .i_valid1     (req1_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_any        (w_any)
  );

  assign w_unused_carry = alu_ALUOut[DATA_W];
  assign w_rsp_ready    = r_owner ? rsp1_ready : rsp0_ready;

  // Every handshake output is qualified by Reset so nothing leaks during reset
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    alu_WF       = 1'b0;
    alu_FunSel   = '0;
    case (r_state)
      ST_IDLE: begin
        w_accept   = Reset & w_any;
        req0_ready = w_accept & ~w_grant;
        req1_ready = w_accept & w_grant;
        if (w_accept) w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        alu_FunSel   = r_op_fun;
        alu_WF       = Reset & r_op_wf;
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp0_valid = Reset & ~r_owner;
        rsp1_valid = Reset & r_owner;
        if (w_rsp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_op_A       <= '0;
      r_op_B       <= '0;
      r_op_fun     <= '0;
      r_op_wf      <= 1'b0;
      r_result     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_op_A       <= w_grant ? req1_A      : req0_A;
        r_op_B       <= w_grant ? req1_B      : req0_B;
        r_op_fun     <= w_grant ? req1_FunSel : req0_FunSel;
        r_op_wf      <= w_grant ? req1_WF     : req0_WF;
      end
      if (r_state == ST_EXEC) r_result <= alu_ALUOut[DATA_W-1:0];
    end
  end

  assign alu_A     = {1'b0, r_op_A};
  assign alu_B     = {1'b0, r_op_B};
  assign rsp_data  = r_result;
  assign rsp_flags = alu_Flags;

endmodule

// File: doc/alu_request_arbiter.md
Name: alu_request_arbiter

Overview:
Shares one ArithmeticLogicUnit instance between two requesters, e.g. the control unit (port 0) and a multi-cycle helper sequencer (port 1).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Fair round-robin arbitration; one operation in flight at a time.
- The block drives the ALU operands, FunSel and WF, captures ALUOut, and returns the result with the ALU's registered flags.

Parameters:
DATA_W, 32, operand/result width; ALU A/B bit 32 is driven 0, ALUOut bit 32 is ignored
FUN_W, 5, FunSel width (bit 4 = 32-bit width select, bits 3:0 = operation)

Ports:
Clock  in  1  single clock, all state updates on rising edge
Reset  in  1  synchronous, active-low reset
req0_valid  in  1  port 0 request valid
req0_ready  out  1  port 0 request accepted this cycle when high with valid
req0_A  in  DATA_W  port 0 operand A
req0_B  in  DATA_W  port 0 operand B
req0_FunSel  in  FUN_W  port 0 ALU function
req0_WF  in  1  port 0 flag-write enable for this operation
req1_valid / req1_ready / req1_A / req1_B / req1_FunSel / req1_WF  same as port 0, for port 1
rsp0_valid  out  1  result for port 0 available
rsp0_ready  in  1  port 0 consumes result
rsp1_valid  out  1  result for port 1 available
rsp1_ready  in  1  port 1 consumes result
rsp_data  out  DATA_W  shared result bus, valid when either rsp*_valid is high
rsp_flags  out  4  shared flags {Z,C,N,O}, valid with rsp_data
alu_A  out  33  to ALU A
alu_B  out  33  to ALU B
alu_FunSel  out  5  to ALU FunSel
alu_WF  out  1  to ALU WF
alu_ALUOut  in  33  from ALU ALUOut
alu_Flags  in  4  from ALU FlagsOut, {Z,C,N,O} = bits 3..0

Behaviour:
- Reset is synchronous, active-low: on a Clock edge with Reset=0, state <= IDLE, last_grant <= 1, op/result registers <= 0.
  - While Reset=0: all req*_ready = 0, all rsp*_valid = 0, alu_WF = 0.
- State machine has three states: IDLE, EXEC, RESP.
- IDLE:
  - grant = 0 if only req0_valid; 1 if only req1_valid; ~last_grant if both.
  - req{grant}_ready = 1 and the other ready = 0. With no request, both ready = 0.
  - On accept: latch A, B, FunSel, WF and owner; last_grant <= owner; go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_A = {1'b0, op_A}, alu_B = {1'b0, op_B}, alu_FunSel = op_FunSel, alu_WF = op_WF.
  - At the edge: result <= alu_ALUOut[31:0]; go to RESP. The ALU updates its flags at this same edge.
- RESP:
  - rsp{owner}_valid = 1, rsp_data = result, rsp_flags = alu_Flags (stable, because alu_WF = 0).
  - Hold until rsp{owner}_ready = 1, then go to IDLE.
  - No new request is accepted in RESP; both req ready = 0.
- Outside EXEC: alu_WF = 0, alu_FunSel = 5'b00000; alu_A/alu_B keep the last operands.
- Latency: accept edge -> rsp_valid high 2 cycles later. Back-to-back throughput is 1 op per 3 cycles when rsp_ready is held high.
- rsp_flags reflects ALU state even when op_WF = 0 (the previous flags are returned unchanged).
- Requester rules and boundaries:
  - A requester must hold valid and payload stable until ready.
  - Dropping valid before accept is legal and simply withdraws the request.
  - Reset in EXEC or RESP aborts the operation with no response; alu_WF = 0 during the reset cycle.
  - No combinational path from rsp*_ready to req*_ready.

Decomposition:
- Package alu_pkg holds:
  - FunSel encodings: ADD = 4'b0100, ADC = 0101, SUB = 0110, AND = 0111, LSL = 1011, and so on; WIDTH32 = bit 4.
  - Flag indices: Z = 3, C = 2, N = 1, O = 0.
  - State enum {IDLE, EXEC, RESP}.
- One sub-module, rr_arbiter2: combinational 2-way grant from (valid0, valid1, last_grant).

Test Plan:
- Single op: port 0 requests A=5, B=7, FunSel=5'b10100, WF=1 -> ready on cycle 0; rsp0_valid at cycle 2 with rsp_data=12, rsp_flags Z=0, N=0.
- Contention after reset: both ports valid simultaneously -> port 0 served first, then port 1. With both continuously valid, grants alternate 0,1,0,1.
- Flag hold: port 1 requests A=1, B=1, FunSel=5'b10110 (SUB), WF=1 -> rsp_data=0, Z=1. Next port 0 requests A|B (FunSel 5'b11000) with WF=0 -> rsp_flags still has Z=1.
- Back-pressure: rsp0_ready held 0 for 5 cycles -> rsp0_valid and rsp_data stable, req1_ready=0 throughout, alu_WF=0.
- Mid-op reset: Reset=0 asserted in EXEC -> next cycle IDLE, no rsp*_valid, alu_WF=0. Requests after reset are served with port 0 priority.
- Withdrawal: req1_valid pulsed for 1 cycle while state is RESP -> never accepted, no response on port 1.
